scroll_sequencer: RTL and testbench
===================================

Name: scroll_sequencer

Overview:
- Controller that sequences the character-index counting used by the word panel.
- Owns a down-counting rate prescaler and an up/down character index with wrap and terminal detection.
- Steps through a word of programmable length, forward or backward, at a programmable rate, for N passes or forever.
- Issues one-cycle step, wrap and done strobes to the display datapath.

Parameters:
- IDX_W, 5, width of character index and length (max word length 2^IDX_W-1).
- DIV_W, 16, width of rate prescaler.
- PASS_W, 4, width of pass counter and repeat count.

Ports:
- clk  in  1  system clock.
- clr  in  1  reset.
- start  in  1  begin sequence; sampled in IDLE only.
- stop  in  1  abort sequence, return to IDLE.
- pause  in  1  level; freezes prescaler and index while high.
- dir  in  1  1 = forward (increment), 0 = backward (decrement); latched at start.
- len  in  IDX_W  word length in characters; latched at start.
- rate  in  DIV_W  step period minus one, in clocks; latched at start.
- repeat_n  in  PASS_W  passes to run; 0 = run forever; latched at start.
- idx  out  IDX_W  current character index.
- step  out  1  one-cycle strobe, coincident with each idx change.
- wrap  out  1  one-cycle strobe when idx wraps from the end index back to the start index.
- done  out  1  one-cycle strobe on sequence completion.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle strobe when start is rejected.

Behaviour:
- Reset: clr is asynchronous, active-high; clock is clk.
  - While clr is high: state=IDLE and idx, step, wrap, done, busy, err, prescaler, pass count are all 0.
  - Assertion of clr mid-sequence aborts immediately.
- All outputs are registered.
- States: IDLE, LOAD, RUN, HOLD, DONE.
- IDLE:
  - start=1, stop=0, len!=0: latch dir/len/rate/repeat_n and go to LOAD.
  - start=1 with len==0: err=1 for one cycle; stay IDLE.
  - start=1 with stop=1: stop wins; stay IDLE, no err.
  - idx holds its last value.
- LOAD (1 cycle):
  - idx = 0 if forward, len-1 if backward.
  - prescaler = rate; pass count = 0; busy=1.
  - Next state RUN.
- RUN: each clock:
  - If prescaler != 0: prescaler decrements.
  - Else: prescaler reloads rate and a step event occurs.
  - Step period is exactly rate+1 clocks; first step occurs rate+1 clocks after entering RUN.
- Step event, non-end index: idx +1 (forward) or -1 (backward); step=1.
- Step event at end index (forward idx==len-1, backward idx==0): pass count increments.
  - If repeat_n!=0 and new pass count == repeat_n: go to DONE; idx unchanged; step=0, wrap=0.
  - Otherwise: idx reloads start index; step=1, wrap=1.
- len==1: every step event is an end-index event. idx stays 0; wrap and step pulse every period.
- repeat_n==0: pass count saturates at max and is never compared; runs until stop or clr.
- HOLD:
  - Entered from RUN when pause=1. Prescaler and idx frozen; no strobes.
  - Returns to RUN when pause=0, resuming the remaining prescaler count (no reload).
- DONE (1 cycle): done=1, busy=1. Next state IDLE, busy=0, idx holds final value.
- stop=1 in LOAD, RUN, HOLD or DONE: next state IDLE; no done pulse; any step event in that cycle is suppressed.
- Priority within a cycle: clr > stop > pause > step event.
- start while busy is ignored; no err.
- Latched parameters are unaffected by input changes mid-sequence.

Test Plan:
- Forward, len=4, rate=2, repeat_n=1:
  - Required: idx 0→1→2→3 with step strobes 3 clocks apart, first step 3 clocks after RUN entry.
  - 4th event: DONE, then done=1 for one cycle; idx stays 3; busy falls the cycle after done; no wrap.
- Backward, len=3, rate=0, repeat_n=2:
  - Required: idx 2,1,0,2,1,0 stepping every clock, one wrap strobe at the 0→2 transition, then done.
- pause mid-period: rate=5; assert pause 2 clocks after a step, hold 10 clocks, release.
  - Required: next step arrives 6 clocks after the previous step plus 10 held clocks; no strobes during HOLD.
- len=1, repeat_n=0, rate=1:
  - Required: idx stays 0, step and wrap both pulse every 2 clocks indefinitely.
  - stop then yields IDLE next clock with no done pulse.
- start with len=0 → err=1 for one cycle, busy stays 0. start with stop=1 in the same cycle → stays IDLE, no err.
- Assert clr asynchronously mid-RUN (between clock edges) → all outputs 0 immediately.
  - After clr release, start behaves normally from IDLE.

Source files
------------

// File: rtl/scroll_sequencer.sv
// Character-index sequencer for the word panel: steps an index through a word
// at a programmable rate, forward or backward, for N passes or forever.
module scroll_sequencer #(
  parameter int IDX_W  = 5,
  parameter int DIV_W  = 16,
  parameter int PASS_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              dir,
  input  logic [IDX_W-1:0]  len,
  input  logic [DIV_W-1:0]  rate,
  input  logic [PASS_W-1:0] repeat_n,
  output logic [IDX_W-1:0]  idx,
  output logic              step,
  output logic              wrap,
  output logic              done,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_HOLD, S_DONE} state_t;

  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
  localparam logic [PASS_W-1:0] PASS_ONE = PASS_W'(1);
  localparam logic [PASS_W-1:0] PASS_MAX = '1;

  state_t            r_state, w_state_next;
  logic              r_dir, w_dir_next;
  logic [IDX_W-1:0]  r_len, w_len_next;
  logic [DIV_W-1:0]  r_rate, w_rate_next;
  logic [PASS_W-1:0] r_rep, w_rep_next;
  logic [IDX_W-1:0]  r_idx, w_idx_next;
  logic [DIV_W-1:0]  r_presc, w_presc_next;
  logic [PASS_W-1:0] r_pass, w_pass_next;
  logic              r_step, w_step_next;
  logic              r_wrap, w_wrap_next;
  logic              r_done, w_done_next;
  logic              r_err, w_err_next;
  logic              r_busy;

  logic [IDX_W-1:0]  w_last;
  logic [IDX_W-1:0]  w_start_idx;
  logic              w_at_end;
  logic [PASS_W-1:0] w_pass_inc;

  assign w_last      = r_len - IDX_ONE;
  assign w_start_idx = r_dir ? '0 : w_last;
  assign w_at_end    = r_dir ? (r_idx == w_last) : (r_idx == '0);
  // Saturating so that a forever run never wraps the pass count
  assign w_pass_inc  = (r_pass == PASS_MAX) ? r_pass : r_pass + PASS_ONE;

  always_comb begin
    w_state_next = r_state;
    w_dir_next   = r_dir;
    w_len_next   = r_len;
    w_rate_next  = r_rate;
    w_rep_next   = r_rep;
    w_idx_next   = r_idx;
    w_presc_next = r_presc;
    w_pass_next  = r_pass;
    w_step_next  = 1'b0;
    w_wrap_next  = 1'b0;
    w_done_next  = 1'b0;
    w_err_next   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          if (len != '0) begin
            w_dir_next   = dir;
            w_len_next   = len;
            w_rate_next  = rate;
            w_rep_next   = repeat_n;
            w_state_next = S_LOAD;
          end else begin
            w_err_next = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (stop) begin
          w_state_next = S_IDLE;
        end else begin
          w_idx_next   = w_start_idx;
          w_presc_next = r_rate;
          w_pass_next  = '0;
          w_state_next = S_RUN;
        end
      end
      S_RUN, S_HOLD: begin
        if (stop) begin
          w_state_next = S_IDLE;
        end else if (pause) begin
          w_state_next = S_HOLD;
        end else begin
          // Leaving HOLD counts as a running cycle, so a pause delays by exactly its length
          w_state_next = S_RUN;
          if (r_presc != '0) begin
            w_presc_next = r_presc - DIV_ONE;
          end else begin
            w_presc_next = r_rate;
            if (w_at_end) begin
              w_pass_next = w_pass_inc;
              if (r_rep != '0 && w_pass_inc == r_rep) begin
                w_state_next = S_DONE;
                w_done_next  = 1'b1;
              end else begin
                w_idx_next  = w_start_idx;
                w_step_next = 1'b1;
                w_wrap_next = 1'b1;
              end
            end else begin
              w_idx_next  = r_dir ? r_idx + IDX_ONE : r_idx - IDX_ONE;
              w_step_next = 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_dir   <= 1'b0;
      r_len   <= '0;
      r_rate  <= '0;
      r_rep   <= '0;
      r_idx   <= '0;
      r_presc <= '0;
      r_pass  <= '0;
      r_step  <= 1'b0;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_dir   <= w_dir_next;
      r_len   <= w_len_next;
      r_rate  <= w_rate_next;
      r_rep   <= w_rep_next;
      r_idx   <= w_idx_next;
      r_presc <= w_presc_next;
      r_pass  <= w_pass_next;
      r_step  <= w_step_next;
      r_wrap  <= w_wrap_next;
      r_done  <= w_done_next;
      r_err   <= w_err_next;
      r_busy  <= (w_state_next != S_IDLE);
    end
  end

  assign idx  = r_idx;
  assign step = r_step;
  assign wrap = r_wrap;
  assign done = r_done;
  assign busy = r_busy;
  assign err  = r_err;

endmodule

// File: tb/tb_scroll_sequencer.sv
// Bench for scroll_sequencer: directed scenarios plus randomized runs checked
// against an event-count model of the index sequence.
module tb_scroll_sequencer;

  logic        clk, clr, start, stop, pause, dir;
  logic [4:0]  len;
  logic [15:0] rate;
  logic [3:0]  repeat_n;
  logic [4:0]  idx;
  logic        step, wrap, done, busy, err;

  int checks   = 0;
  int failures = 0;
  int exp_last_idx = 0;

  scroll_sequencer #(.IDX_W(5), .DIV_W(16), .PASS_W(4)) dut (
    .clk(clk), .clr(clr), .start(start), .stop(stop), .pause(pause),
    .dir(dir), .len(len), .rate(rate), .repeat_n(repeat_n),
    .idx(idx), .step(step), .wrap(wrap), .done(done), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] outs();
    return {22'd0, idx, step, wrap, done, busy, err};
  endfunction

  function automatic logic [31:0] pack(input int i, input bit s, input bit w,
                                        input bit d, input bit b, input bit e);
    return {22'd0, 5'(i), s, w, d, b, e};
  endfunction

  // Index after n step events: position n mod len within the pass
  function automatic int idx_of(input int n, input int l, input bit d);
    int k;
    k = n % l;
    return d ? k : l - 1 - k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full sequence; stop_after (>=2) forces stop before that edge, 0 = run to completion
  task automatic run_seq(input bit d, input int l, input int rt, input int rp,
                         input bit pz, input int stop_after, input string tag);
    int  r, cyc, n, period, total, cur;
    bit  p_prev, stop_now, strobe, in_done, finished;
    bit  e_step, e_wrap, e_done, e_busy;
    period = rt + 1;
    total  = (rp == 0) ? 0 : l * rp;
    dir = d; len = 5'(l); rate = 16'(rt); repeat_n = 4'(rp);
    start = 1'b1; stop = 1'b0; pause = 1'b0;
    tick();
    chk({tag, " load"}, outs(), pack(exp_last_idx, 0, 0, 0, 1, 0));
    cur = exp_last_idx;
    r = 0; cyc = 0; in_done = 0; finished = 0;
    while (!finished && cyc < 4000) begin
      start    = 1'($urandom);
      dir      = 1'($urandom);
      len      = 5'($urandom);
      rate     = 16'($urandom);
      repeat_n = 4'($urandom);
      pause    = pz ? ($urandom_range(0, 4) == 0) : 1'b0;
      stop_now = (stop_after != 0) && (cyc + 1 == stop_after);
      stop     = stop_now;
      p_prev   = pause;
      tick();
      cyc++;
      e_step = 0; e_wrap = 0; e_done = 0; e_busy = 1;
      if (stop_now || in_done) begin
        e_busy   = 0;
        finished = 1;
      end else if (cyc == 1) begin
        cur = idx_of(0, l, d);
      end else begin
        if (!p_prev) r++;
        strobe = !p_prev && (r % period == 0);
        n = r / period;
        if (strobe && total != 0 && n == total) begin
          e_done  = 1;
          in_done = 1;
        end else begin
          cur    = idx_of(n, l, d);
          e_step = strobe;
          e_wrap = strobe && (n % l == 0);
        end
      end
      chk(tag, outs(), pack(cur, e_step, e_wrap, e_done, e_busy, 0));
    end
    start = 1'b0; stop = 1'b0; pause = 1'b0;
    exp_last_idx = cur;
  endtask

  initial begin
    int k, sa, l, rt, rp, t;
    bit d, seen, quiet;
    clr = 1'b1; start = 0; stop = 0; pause = 0; dir = 0;
    len = '0; rate = '0; repeat_n = '0;
    #1;
    chk("reset_outputs", outs(), 32'd0);
    repeat (3) @(posedge clk);
    #2 clr = 1'b0;
    tick();
    chk("reset_idle", outs(), 32'd0);

    run_seq(1'b1, 4, 2, 1, 1'b0, 0, "fwd_len4_rate2");
    run_seq(1'b0, 3, 0, 2, 1'b0, 0, "bwd_len3_rate0");

    // Pause mid-period: 6-clock period stretched by exactly the 10 held clocks
    dir = 1'b1; len = 5'd4; rate = 16'd5; repeat_n = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    seen = 0; k = 0;
    while (!seen && k < 20) begin tick(); k++; seen = step; end
    chk("pause_first_step_latency", 32'(k), 32'd7);
    tick(); tick();
    pause = 1'b1;
    quiet = 1;
    repeat (10) begin tick(); quiet = quiet && !step && !wrap && !done && busy; end
    chk("pause_hold_quiet", {31'd0, quiet}, 32'd1);
    pause = 1'b0;
    seen = 0; k = 0;
    while (!seen && k < 20) begin tick(); k++; seen = step; end
    chk("pause_step_gap", 32'(k + 12), 32'd16);
    chk("pause_idx_after", 32'(idx), 32'd2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("pause_stop_idle", outs(), pack(2, 0, 0, 0, 0, 0));
    exp_last_idx = 2;

    // Rejected starts
    len = 5'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_len0", outs(), pack(exp_last_idx, 0, 0, 0, 0, 1));
    tick();
    chk("err_one_cycle", outs(), pack(exp_last_idx, 0, 0, 0, 0, 0));
    len = 5'd5; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("start_with_stop", outs(), pack(exp_last_idx, 0, 0, 0, 0, 0));
    tick();
    chk("start_with_stop_idle", outs(), pack(exp_last_idx, 0, 0, 0, 0, 0));

    run_seq(1'b1, 1, 1, 0, 1'b0, 13, "len1_forever");

    // Asynchronous clear between clock edges
    dir = 1'b1; len = 5'd5; rate = 16'd1; repeat_n = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    #3 clr = 1'b1;
    #1;
    chk("async_clr", outs(), 32'd0);
    #3 clr = 1'b0;
    tick();
    chk("after_clr_idle", outs(), 32'd0);
    exp_last_idx = 0;
    run_seq(1'b0, 5, 1, 1, 1'b0, 0, "after_clr_run");

    for (int trial = 0; trial < 12; trial++) begin
      d  = 1'($urandom);
      l  = $urandom_range(1, 7);
      rt = $urandom_range(0, 3);
      rp = $urandom_range(0, 3);
      t  = l * (rp == 0 ? 1 : rp) * (rt + 1);
      if (rp == 0) sa = $urandom_range(5, 45);
      else sa = ($urandom_range(0, 2) == 0) ? $urandom_range(2, t + 1) : 0;
      run_seq(d, l, rt, rp, 1'b1, sa, $sformatf("rand%0d", trial));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
